alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 6, operand/result width in bits; legal range 4..32.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to launch an operation; sampled only when busy=0.
REQ-006 input1  input  WIDTH  operand A, two's complement.
REQ-007 input2  input  WIDTH  operand B, two's complement.
REQ-008 m, f, x, n  input  1 each  opcode bits; opcode = {m,f,x,n}.
REQ-009 result  output  WIDTH  registered result, held until the next done.
REQ-010 done  output  1  one-cycle pulse; result and flags valid in that cycle.
REQ-011 busy  output  1  high while an accepted operation is in progress.
REQ-012 zero, negative, carry, overflow, err  output  1 each  registered status flags, updated with done.

Function
REQ-013 Opcodes: 0000 A; 0001 B; 0010 -A; 0011 -B; 0100 signed A<B (result 1 or 0 in LSB, upper bits 0); 0101 bitwise A xnor B; 0110 A+B; 0111 A-B.
REQ-014 Extended opcodes: 1000 A*B (low WIDTH bits, multi-cycle); 1001 A<<B; 1010 A>>>B (arithmetic); 1011 A==B (LSB result); 1100-1111 reserved.
REQ-015 Operands and opcode are captured on the cycle start=1 and busy=0; later input changes do not affect the operation.
REQ-016 FSM states: IDLE, EXEC, MUL, DONE; IDLE->EXEC on start with opcode other than 1000; IDLE->MUL on start with 1000; EXEC->DONE after 1 cycle; MUL->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-017 Latency: start in cycle T gives done in cycle T+2 for single-cycle ops and T+WIDTH+2 for multiply.
REQ-018 busy is high from cycle T+1 through the done cycle inclusive; start with busy=1 is ignored with no effect.
REQ-019 Back-to-back: start asserted in the cycle after done is accepted.
REQ-020 Multiply is an iterative shift-add over WIDTH cycles, one partial product per cycle.
REQ-021 zero = (result == 0); negative = result[WIDTH-1]; set for every opcode.
REQ-022 carry: carry-out of A+B for 0110; carry-out of A+~B+1 (1 = no borrow) for 0111; 1 if upper WIDTH bits of the unsigned 2*WIDTH product are nonzero for 1000; 0 otherwise.
REQ-023 overflow: signed overflow for 0110/0111; 1 for 0010/0011 when the operand equals the most-negative value; 0 otherwise.
REQ-024 Shifts use B as unsigned amount; amount >= WIDTH gives 0 for 1001 and all sign bits for 1010.
REQ-025 Reserved opcodes complete with single-cycle latency, result 0, err=1; err=0 for all legal opcodes.
REQ-026 result and flags hold their values between done pulses.

Reset
REQ-027 While reset=1 at a clock edge: state IDLE, result 0, done 0, busy 0, all flags 0.
REQ-028 Reset during EXEC/MUL/DONE aborts the operation: no done is issued for it and no captured value reaches result.
REQ-029 start asserted in the same cycle as reset is ignored.

Verification (WIDTH=6)
REQ-030 A=000111, B=000000, op 0000, start at T -> done at T+2, result 000111, zero 0, err 0.
REQ-031 A=000111, B=000011, op 0111 -> result 000100, carry 1, overflow 0; A=011111, B=000001, op 0110 -> result 100000, overflow 1, negative 1.
REQ-032 A=000101, B=000011, op 1000, start at T; second start at T+3 -> single done at T+8, result 001111, carry 0, busy high T+1..T+8.
REQ-033 A=100000, op 0010 -> result 100000, overflow 1; A=010101, B=101101, op 0101 -> result 000111; A=000011, B=000110, op 0100 -> result 000001.
REQ-034 A=100100, B=000111, op 1010 -> result 111111; op 1001 -> 000000; op 1101 -> result 000000, err 1.
REQ-035 Multiply started at T, reset high at T+3 -> busy 0 and result 0 from T+4, no done; new start at T+5 completes normally.

Source files
------------

// File: rtl/alu_seq_if.sv
// Handshake/bus bundle for alu_seq: launch request, operands, opcode,
// and the registered result with its status flags.
interface alu_seq_if #(
   parameter int WIDTH = 6
);
   logic             start;
   logic [WIDTH-1:0] input1;
   logic [WIDTH-1:0] input2;
   logic             m;
   logic             f;
   logic             x;
   logic             n;
   logic [WIDTH-1:0] result;
   logic             done;
   logic             busy;
   logic             zero;
   logic             negative;
   logic             carry;
   logic             overflow;
   logic             err;

   modport master (
      output start, input1, input2, m, f, x, n,
      input  result, done, busy, zero, negative, carry, overflow, err
   );

   modport slave (
      input  start, input1, input2, m, f, x, n,
      output result, done, busy, zero, negative, carry, overflow, err
   );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops complete two cycles after start,
// multiply runs an iterative shift-add over WIDTH cycles plus one finish cycle.
// Result and flags are registered and held between done pulses.
module alu_seq #(
   parameter int WIDTH = 6
) (
   input  logic     clk,
   input  logic     reset,
   alu_seq_if.slave bus
);
   localparam int               MSB     = WIDTH - 1;
   localparam int               CW      = $clog2(WIDTH + 1);
   localparam logic [3:0]       OP_MUL  = 4'b1000;
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [3:0]         op_q;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic [WIDTH-1:0]   result_q;
   logic               done_q, busy_q;
   logic               zero_q, neg_q, carry_q, ovf_q, err_q;

   logic [3:0]         op_in;
   logic               accept;
   logic               load_result;

   logic [WIDTH:0]     sum_s, dif_s;
   logic [WIDTH-1:0]   ex_res;
   logic               ex_carry, ex_ovf, ex_err;
   logic [WIDTH-1:0]   fin_res;
   logic               fin_carry, fin_ovf, fin_err;

   assign op_in       = {bus.m, bus.f, bus.x, bus.n};
   assign accept      = bus.start && (state_q == S_IDLE);
   assign load_result = (state_q == S_EXEC) || ((state_q == S_MUL) && (state_d == S_DONE));

   // Next-state and multiplier datapath: one partial product per MUL cycle,
   // the cycle after the last iteration hands the product to the result register.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (op_in == OP_MUL) begin
                  state_d = S_MUL;
               end else begin
                  state_d = S_EXEC;
               end
               acc_d    = '0;
               mcand_d  = {{WIDTH{1'b0}}, bus.input1};
               mplier_d = bus.input2;
               cnt_d    = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EXEC: state_d = S_DONE;
         S_MUL: begin
            if (cnt_q == CW'(WIDTH)) begin
               state_d = S_DONE;
            end else begin
               if (mplier_q[0]) begin
                  acc_d = acc_q + mcand_q;
               end else begin
                  acc_d = acc_q;
               end
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Single-cycle operation datapath on the captured operands and opcode.
   always_comb begin
      ex_res   = '0;
      ex_carry = 1'b0;
      ex_ovf   = 1'b0;
      ex_err   = 1'b0;
      sum_s    = {1'b0, a_q} + {1'b0, b_q};
      dif_s    = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
      case (op_q)
         4'b0000: ex_res = a_q;
         4'b0001: ex_res = b_q;
         4'b0010: begin
            ex_res = -a_q;
            ex_ovf = (a_q == MIN_VAL);
         end
         4'b0011: begin
            ex_res = -b_q;
            ex_ovf = (b_q == MIN_VAL);
         end
         4'b0100: ex_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         4'b0101: ex_res = ~(a_q ^ b_q);
         4'b0110: begin
            ex_res   = sum_s[WIDTH-1:0];
            ex_carry = sum_s[WIDTH];
            ex_ovf   = (a_q[MSB] == b_q[MSB]) && (sum_s[MSB] != a_q[MSB]);
         end
         4'b0111: begin
            ex_res   = dif_s[WIDTH-1:0];
            ex_carry = dif_s[WIDTH];
            ex_ovf   = (a_q[MSB] != b_q[MSB]) && (dif_s[MSB] != a_q[MSB]);
         end
         4'b1000: ex_res = '0;  // multiply never passes through EXEC
         4'b1001: begin
            if (32'(b_q) >= 32'(WIDTH)) begin
               ex_res = '0;
            end else begin
               ex_res = a_q << b_q;
            end
         end
         4'b1010: begin
            if (32'(b_q) >= 32'(WIDTH)) begin
               ex_res = {WIDTH{a_q[MSB]}};
            end else begin
               ex_res = $signed(a_q) >>> b_q;
            end
         end
         4'b1011: ex_res = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
         default: ex_err = 1'b1;  // reserved opcodes: result 0, err set
      endcase
   end

   // Select the value that lands in the result register: product or single-cycle result.
   always_comb begin
      if (state_q == S_MUL) begin
         fin_res   = acc_q[WIDTH-1:0];
         fin_carry = |acc_q[2*WIDTH-1:WIDTH];
         fin_ovf   = 1'b0;
         fin_err   = 1'b0;
      end else begin
         fin_res   = ex_res;
         fin_carry = ex_carry;
         fin_ovf   = ex_ovf;
         fin_err   = ex_err;
      end
   end

   // State, operand capture and registered outputs; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= 4'b0000;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         busy_q   <= (state_d != S_IDLE);
         done_q   <= (state_d == S_DONE);
         if (accept) begin
            a_q  <= bus.input1;
            b_q  <= bus.input2;
            op_q <= op_in;
         end
         if (load_result) begin
            result_q <= fin_res;
            zero_q   <= (fin_res == '0);
            neg_q    <= fin_res[MSB];
            carry_q  <= fin_carry;
            ovf_q    <= fin_ovf;
            err_q    <= fin_err;
         end
      end
   end

   assign bus.result   = result_q;
   assign bus.done     = done_q;
   assign bus.busy     = busy_q;
   assign bus.zero     = zero_q;
   assign bus.negative = neg_q;
   assign bus.carry    = carry_q;
   assign bus.overflow = ovf_q;
   assign bus.err      = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=6.
// Flags are compared as the vector {zero, negative, carry, overflow, err}.
module tb_alu_seq;
   localparam int W = 6;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   alu_seq_if #(.WIDTH(W)) bus ();

   alu_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] flags();
      return {bus.zero, bus.negative, bus.carry, bus.overflow, bus.err};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Assert start for exactly one cycle; returns in cycle T+1.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
      step();
      bus.start  = 1'b1;
      bus.input1 = a;
      bus.input2 = b;
      {bus.m, bus.f, bus.x, bus.n} = op;
      step();
      bus.start  = 1'b0;
      bus.input1 = 6'b101010;
      bus.input2 = 6'b010101;
      {bus.m, bus.f, bus.x, bus.n} = 4'b1111;
   endtask

   // Wait (bounded) for done; cyc is the cycle offset from T at entry.
   task automatic wait_done(input string tag, input int start_cyc, input int exp_lat);
      int cyc;
      int busy_bad;
      cyc      = start_cyc;
      busy_bad = 0;
      while (bus.done !== 1'b1 && cyc < 40) begin
         if (bus.busy !== 1'b1) busy_bad++;
         step();
         cyc++;
      end
      chk({tag, "_lat"}, cyc, exp_lat);
      chk({tag, "_busy"}, busy_bad, 0);
      chk({tag, "_busydone"}, {31'd0, bus.busy}, 32'd1);
   endtask

   task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [3:0] op, input int lat,
                      input logic [W-1:0] exp_res, input logic [4:0] exp_flags);
      launch(a, b, op);
      wait_done(tag, 1, lat);
      chk({tag, "_res"}, {26'd0, bus.result}, {26'd0, exp_res});
      chk({tag, "_flags"}, {27'd0, flags()}, {27'd0, exp_flags});
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.input1 = 6'b000000;
      bus.input2 = 6'b000000;
      {bus.m, bus.f, bus.x, bus.n} = 4'b0000;
      step();
      step();
      chk("rst_res", {26'd0, bus.result}, 32'd0);
      chk("rst_ctl", {30'd0, bus.done, bus.busy}, 32'd0);
      chk("rst_flags", {27'd0, flags()}, 32'd0);

      // start together with reset is ignored
      bus.start = 1'b1;
      step();
      reset     = 1'b0;
      bus.start = 1'b0;
      step();
      chk("rst_start_busy", {31'd0, bus.busy}, 32'd0);

      //   tag          A          B          op       lat result     {z,n,c,v,e}
      run("pass_a",  6'b000111, 6'b000000, 4'b0000, 2, 6'b000111, 5'b00000);
      run("sub",     6'b000111, 6'b000011, 4'b0111, 2, 6'b000100, 5'b00100);
      run("add_ovf", 6'b011111, 6'b000001, 4'b0110, 2, 6'b100000, 5'b01010);
      run("add_cz",  6'b111111, 6'b000001, 4'b0110, 2, 6'b000000, 5'b10100);
      run("sub_ovf", 6'b100000, 6'b000001, 4'b0111, 2, 6'b011111, 5'b00110);
      run("neg_min", 6'b100000, 6'b000000, 4'b0010, 2, 6'b100000, 5'b01010);
      run("negb",    6'b000000, 6'b000101, 4'b0011, 2, 6'b111011, 5'b01000);
      run("pass_b",  6'b000001, 6'b110000, 4'b0001, 2, 6'b110000, 5'b01000);
      run("xnor",    6'b010101, 6'b101101, 4'b0101, 2, 6'b000111, 5'b00000);
      run("slt",     6'b000011, 6'b000110, 4'b0100, 2, 6'b000001, 5'b00000);
      run("slt_neg", 6'b000011, 6'b111110, 4'b0100, 2, 6'b000000, 5'b10000);
      run("asr_big", 6'b100100, 6'b000111, 4'b1010, 2, 6'b111111, 5'b01000);
      run("asr_2",   6'b100100, 6'b000010, 4'b1010, 2, 6'b111001, 5'b01000);
      run("shl_big", 6'b100100, 6'b000111, 4'b1001, 2, 6'b000000, 5'b10000);
      run("shl_2",   6'b000101, 6'b000010, 4'b1001, 2, 6'b010100, 5'b00000);
      run("eq",      6'b101010, 6'b101010, 4'b1011, 2, 6'b000001, 5'b00000);
      run("rsvd",    6'b100100, 6'b000111, 4'b1101, 2, 6'b000000, 5'b10001);
      run("mul_cy",  6'b011110, 6'b000011, 4'b1000, 8, 6'b011010, 5'b00100);

      // result and flags hold between done pulses
      step();
      step();
      step();
      chk("hold_res", {26'd0, bus.result}, 32'd26);
      chk("hold_flags", {27'd0, flags()}, 32'd4);
      chk("hold_ctl", {30'd0, bus.done, bus.busy}, 32'd0);

      // multiply with a second start at T+3 that must be ignored
      launch(6'b000101, 6'b000011, 4'b1000);
      step();
      step();
      bus.start  = 1'b1;
      bus.input1 = 6'b111111;
      bus.input2 = 6'b000001;
      {bus.m, bus.f, bus.x, bus.n} = 4'b0000;
      step();
      bus.start = 1'b0;
      wait_done("mul", 4, 8);
      chk("mul_res", {26'd0, bus.result}, 32'd15);
      chk("mul_flags", {27'd0, flags()}, 32'd0);
      step();
      chk("mul_after", {30'd0, bus.done, bus.busy}, 32'd0);
      step();
      step();
      chk("mul_nodup", {31'd0, bus.done}, 32'd0);

      // reset during multiply aborts it
      launch(6'b000101, 6'b000011, 4'b1000);
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_ctl", {30'd0, bus.done, bus.busy}, 32'd0);
      chk("abort_res", {26'd0, bus.result}, 32'd0);
      chk("abort_flags", {27'd0, flags()}, 32'd0);
      run("post_rst", 6'b000010, 6'b000011, 4'b1000, 8, 6'b000110, 5'b00000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
